alarm_buzz_ctrl: RTL and testbench

ALARM_BUZZ_CTRL -- requirements
Module: alarm_buzz_ctrl

---
 rtl/alarm_buzz_ctrl.sv | 145 ++++++++++++++
 tb/tb_alarm_buzz_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_buzz_ctrl.sv
// Alarm ring/snooze sequencer for a wall clock.
// Detects the alarm time (hh:mm:00, rising edge of the match), then beeps the
// buzzer in P_ON_TICKS/P_OFF_TICKS cadence for up to P_RING_TICKS ticks.
// Snooze pauses ringing for P_SNOOZE_TICKS, up to P_MAX_SNOOZE times per event.
// Ports:
//   clk, rst_n                    system clock, async active-low reset
//   i_hour/i_min/i_sec            current time
//   i_alarm_hour/i_alarm_min      alarm set time
//   i_alarm_arm                   level, alarm enabled (low forces idle)
//   i_stop, i_snooze              single-cycle user pulses
//   o_buzz_en                     buzzer enable (beep on phase)
//   o_ringing                     alarm event ringing (on or off phase)
//   o_snoozed                     snooze pause in progress
//   o_snooze_cnt                  snoozes used in the current event
module alarm_buzz_ctrl #(
  parameter int unsigned P_TICK_DIV     = 5000000,
  parameter int unsigned P_ON_TICKS     = 5,
  parameter int unsigned P_OFF_TICKS    = 5,
  parameter int unsigned P_RING_TICKS   = 600,
  parameter int unsigned P_SNOOZE_TICKS = 3000,
  parameter int unsigned P_MAX_SNOOZE   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [4:0] i_alarm_hour,
  input  logic [5:0] i_alarm_min,
  input  logic       i_alarm_arm,
  input  logic       i_stop,
  input  logic       i_snooze,
  output logic       o_buzz_en,
  output logic       o_ringing,
  output logic       o_snoozed,
  output logic [1:0] o_snooze_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RING_ON  = 2'd1,
    RING_OFF = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  localparam logic [25:0] TICK_LAST = 26'(P_TICK_DIV - 1);
  localparam logic [15:0] ON_LAST   = 16'(P_ON_TICKS - 1);
  localparam logic [15:0] OFF_LAST  = 16'(P_OFF_TICKS - 1);
  localparam logic [15:0] RING_LAST = 16'(P_RING_TICKS - 1);
  localparam logic [15:0] SNZ_LAST  = 16'(P_SNOOZE_TICKS - 1);
  localparam logic [1:0]  MAX_SNZ   = 2'(P_MAX_SNOOZE);

  state_t      state, state_nx;
  logic [25:0] pre_cnt;
  logic [15:0] phase_cnt;
  logic [15:0] ring_cnt;
  logic [15:0] phase_last;
  logic        match, match_d, trigger;
  logic        tick, phase_done, ring_done;
  logic        snooze_take;
  logic        state_chg;

  assign match   = (i_hour == i_alarm_hour) && (i_min == i_alarm_min) && (i_sec == 6'd0);
  assign trigger = match && !match_d && i_alarm_arm;

  assign tick       = (pre_cnt == TICK_LAST);
  assign ring_done  = tick && (ring_cnt == RING_LAST);
  assign phase_done = tick && (phase_cnt == phase_last);
  assign state_chg  = (state_nx != state);

  always_comb begin
    phase_last = SNZ_LAST;
    if (state == RING_ON)       phase_last = ON_LAST;
    else if (state == RING_OFF) phase_last = OFF_LAST;
  end

  // Priority on a shared edge: disarm/stop, then snooze, then burst expiry,
  // then the on/off phase toggle.
  always_comb begin
    state_nx    = state;
    snooze_take = 1'b0;
    if (!i_alarm_arm) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (trigger) state_nx = RING_ON;
        end
        RING_ON, RING_OFF: begin
          if (i_stop) begin
            state_nx = IDLE;
          end else if (i_snooze && (o_snooze_cnt < MAX_SNZ)) begin
            state_nx    = SNOOZE;
            snooze_take = 1'b1;
          end else if (ring_done) begin
            state_nx = IDLE;
          end else if (phase_done) begin
            state_nx = (state == RING_ON) ? RING_OFF : RING_ON;
          end
        end
        SNOOZE: begin
          if (i_stop)          state_nx = IDLE;
          else if (phase_done) state_nx = RING_ON;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      match_d      <= 1'b1;
      pre_cnt      <= '0;
      phase_cnt    <= '0;
      ring_cnt     <= '0;
      o_snooze_cnt <= '0;
    end else begin
      state   <= state_nx;
      match_d <= match;

      // Restarting the prescaler on every transition keeps each dwell an
      // exact multiple of the tick period.
      if (state_chg || tick) pre_cnt <= '0;
      else                   pre_cnt <= pre_cnt + 1'b1;

      if (state_chg)                   phase_cnt <= '0;
      else if (tick && state != IDLE)  phase_cnt <= phase_cnt + 1'b1;

      // Burst length spans both beep phases; only a fresh burst restarts it.
      if ((state == IDLE || state == SNOOZE) && state_nx == RING_ON)
        ring_cnt <= '0;
      else if (tick && (state == RING_ON || state == RING_OFF))
        ring_cnt <= ring_cnt + 1'b1;

      if (state_nx == IDLE) o_snooze_cnt <= '0;
      else if (snooze_take) o_snooze_cnt <= o_snooze_cnt + 1'b1;
    end
  end

  assign o_buzz_en = (state == RING_ON);
  assign o_ringing = (state == RING_ON) || (state == RING_OFF);
  assign o_snoozed = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_buzz_ctrl.sv
// Self-checking bench for alarm_buzz_ctrl: a vector table, hand-written
// multi-cycle sequences (full burst, snooze, async reset) and a randomized
// run against a cycle-countdown reference model.
module tb_alarm_buzz_ctrl;

  localparam int unsigned DIV  = 4;
  localparam int unsigned ON   = 2;
  localparam int unsigned OFF  = 2;
  localparam int unsigned RING = 20;
  localparam int unsigned SNZ  = 6;
  localparam int unsigned MAXS = 1;

  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_ON0  = 5'b11000;
  localparam logic [4:0] E_OFF0 = 5'b01000;
  localparam logic [4:0] E_SNZ1 = 5'b00101;
  localparam logic [4:0] E_ON1  = 5'b11001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hour, ahour;
  logic [5:0] min, sec, amin;
  logic       arm, stop, snooze;
  logic       o_buzz_en, o_ringing, o_snoozed;
  logic [1:0] o_snooze_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alarm_buzz_ctrl #(
    .P_TICK_DIV    (DIV),
    .P_ON_TICKS    (ON),
    .P_OFF_TICKS   (OFF),
    .P_RING_TICKS  (RING),
    .P_SNOOZE_TICKS(SNZ),
    .P_MAX_SNOOZE  (MAXS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_hour      (hour),
    .i_min       (min),
    .i_sec       (sec),
    .i_alarm_hour(ahour),
    .i_alarm_min (amin),
    .i_alarm_arm (arm),
    .i_stop      (stop),
    .i_snooze    (snooze),
    .o_buzz_en   (o_buzz_en),
    .o_ringing   (o_ringing),
    .o_snoozed   (o_snoozed),
    .o_snooze_cnt(o_snooze_cnt)
  );

  typedef struct {
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic        arm;
    logic        stop;
    logic        snz;
    int unsigned reps;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int h, input int m, input int s, input logic a,
                         input logic st, input logic sn, input int unsigned reps,
                         input logic [4:0] exp);
    vec_t v;
    v.h = 5'(h); v.m = 6'(m); v.s = 6'(s);
    v.arm = a; v.stop = st; v.snz = sn; v.reps = reps; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = 5'(h); min = 6'(m); sec = 6'(s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {o_buzz_en, o_ringing, o_snoozed, o_snooze_cnt};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {buzz,ring,snz,cnt}=%b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges k=0..80 from burst entry: 8 cycles on / 8 off, idle at edge 80.
  task automatic burst_check(input logic [1:0] cnt_exp, input int snz_at);
    logic [4:0] exp;
    for (int k = 0; k <= 80; k++) begin
      snooze = (k == snz_at);
      step();
      snooze = 1'b0;
      if (k < 80) exp = {((k / 8) % 2 == 0), 1'b1, 1'b0, cnt_exp};
      else        exp = E_IDLE;
      check("burst", exp);
    end
  endtask

  // Reference model: counts remaining cycles per phase and per burst.
  localparam int M_IDLE = 0, M_ON = 1, M_OFF = 2, M_SNZ = 3;
  int          m_mode;
  int unsigned m_left, m_burst;
  logic [1:0]  m_snz;
  bit          m_prev;

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_burst = 0; m_snz = 2'd0; m_prev = 1'b1;
  endtask

  task automatic model_edge();
    bit match, trig;
    match  = (hour == ahour) && (min == amin) && (sec == 6'd0);
    trig   = match && !m_prev && arm;
    m_prev = match;
    if (!arm) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (trig) begin m_mode = M_ON; m_left = ON * DIV; m_burst = RING * DIV; end
    end else if (stop) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_SNZ) begin
      m_left--;
      if (m_left == 0) begin m_mode = M_ON; m_left = ON * DIV; m_burst = RING * DIV; end
    end else if (snooze && (int'(m_snz) < int'(MAXS))) begin
      m_mode = M_SNZ; m_snz = m_snz + 2'd1; m_left = SNZ * DIV;
    end else begin
      m_left--; m_burst--;
      if (m_burst == 0) m_mode = M_IDLE;
      else if (m_left == 0) begin
        m_mode = (m_mode == M_ON) ? M_OFF : M_ON;
        m_left = (m_mode == M_ON) ? ON * DIV : OFF * DIV;
      end
    end
    if (m_mode == M_IDLE) m_snz = 2'd0;
  endtask

  function automatic logic [4:0] model_exp();
    return {m_mode == M_ON, (m_mode == M_ON) || (m_mode == M_OFF), m_mode == M_SNZ, m_snz};
  endfunction

  initial begin
    int unsigned hold;
    int          sel;

    ahour = 5'd7; amin = 6'd30;
    arm = 1'b1; stop = 1'b0; snooze = 1'b0;
    set_time(7, 29, 59);
    rst_n = 1'b0;
    #1;
    check("reset_state", E_IDLE);
    step(); step();
    rst_n = 1'b1;

    // Table: trigger, cadence, stop+snooze, no retrigger, disarm cases.
    add_vec(7, 29, 59, 1, 0, 0, 2,  E_IDLE);
    add_vec(7, 30, 0,  1, 0, 0, 1,  E_ON0);
    add_vec(7, 30, 0,  1, 0, 0, 7,  E_ON0);
    add_vec(7, 30, 0,  1, 0, 0, 8,  E_OFF0);
    add_vec(7, 30, 0,  1, 0, 0, 3,  E_ON0);
    add_vec(7, 30, 0,  1, 1, 1, 1,  E_IDLE);
    add_vec(7, 30, 0,  1, 0, 0, 10, E_IDLE);
    add_vec(7, 29, 59, 0, 0, 0, 1,  E_IDLE);
    add_vec(7, 30, 0,  0, 0, 0, 1,  E_IDLE);
    add_vec(7, 30, 0,  1, 0, 0, 3,  E_IDLE);
    add_vec(7, 29, 59, 1, 0, 0, 1,  E_IDLE);
    add_vec(7, 30, 0,  1, 0, 0, 1,  E_ON0);
    add_vec(7, 30, 0,  1, 0, 1, 1,  E_SNZ1);
    add_vec(7, 30, 0,  1, 0, 0, 5,  E_SNZ1);
    add_vec(7, 30, 0,  0, 0, 0, 1,  E_IDLE);
    add_vec(7, 30, 0,  1, 0, 0, 3,  E_IDLE);

    foreach (tbl[i]) begin
      for (int unsigned r = 0; r < tbl[i].reps; r++) begin
        set_time(int'(tbl[i].h), int'(tbl[i].m), int'(tbl[i].s));
        arm    = tbl[i].arm;
        stop   = (r == 0) ? tbl[i].stop : 1'b0;
        snooze = (r == 0) ? tbl[i].snz  : 1'b0;
        step();
        check($sformatf("table_row%0d", i), tbl[i].exp);
      end
    end
    stop = 1'b0; snooze = 1'b0; arm = 1'b1;

    // Full 80-cycle burst, then no retrigger while the time still matches.
    set_time(7, 29, 59); step(); check("pre_burst", E_IDLE);
    set_time(7, 30, 0);
    burst_check(2'd0, -1);
    for (int i = 0; i < 3; i++) begin step(); check("post_expiry", E_IDLE); end

    // Snooze 3 cycles in: 24-cycle pause, fresh burst, second snooze ignored.
    set_time(7, 29, 59); step(); check("pre_snooze", E_IDLE);
    set_time(7, 30, 0);
    for (int i = 0; i < 3; i++) begin step(); check("ring_before_snooze", E_ON0); end
    snooze = 1'b1; step(); snooze = 1'b0;
    check("snooze_entry", E_SNZ1);
    for (int i = 0; i < 23; i++) begin step(); check("snooze_dwell", E_SNZ1); end
    burst_check(2'd1, 1);
    step(); check("after_snooze_burst", E_IDLE);

    // Asynchronous reset mid-ring; release while the time matches.
    set_time(7, 29, 59); step();
    set_time(7, 30, 0);
    step(); step(); step();
    check("ring_before_reset", E_ON0);
    #2 rst_n = 1'b0;
    #1 check("async_reset", E_IDLE);
    step(); step();
    check("reset_held", E_IDLE);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); check("release_on_match", E_IDLE); end

    // Release before the match second: fires exactly once.
    rst_n = 1'b0;
    set_time(7, 29, 59);
    step();
    rst_n = 1'b1;
    step(); check("release_pre_match", E_IDLE);
    set_time(7, 30, 0);
    step(); check("trigger_after_release", E_ON0);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_after_release", E_IDLE);
    for (int i = 0; i < 3; i++) begin step(); check("single_fire", E_IDLE); end

    // Randomized run against the reference model.
    rst_n = 1'b0;
    set_time(7, 29, 59);
    arm = 1'b1; stop = 1'b0; snooze = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hold == 0) begin
        sel  = int'($urandom_range(0, 5));
        hold = $urandom_range(1, 120);
        case (sel)
          0, 1, 2: set_time(7, 30, 0);
          3:       set_time(7, 29, 59);
          4:       set_time(7, 30, 1);
          default: set_time(8, 30, 0);
        endcase
      end
      hold--;
      arm    = ($urandom_range(0, 199) != 0);
      stop   = ($urandom_range(0, 149) == 0);
      snooze = ($urandom_range(0, 24) == 0);
      model_edge();
      step();
      check("random", model_exp());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
